// File: rtl/four_bit_serializer_pkg.sv
// rtl/four_bit_serializer_pkg.sv - shared types and defaults for the serializer
package four_bit_serializer_pkg;

  // Two-state transmitter: idle (ready for a word) or shifting a held word out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serializer_bit_counter.sv
// rtl/serializer_bit_counter.sv - modulo-WIDTH bit position counter
module serializer_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          is_last
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count   = count_q;
  assign is_last = (count_q == CW'(WIDTH - 1));

  // Clear wins over increment so a reload always restarts at bit 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = is_last ? '0 : count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/four_bit_serializer.sv
// rtl/four_bit_serializer.sv - parallel-in serial-out transmitter with frame marks
module four_bit_serializer
  import four_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]   count;
  logic            is_last;
  logic            beat;
  logic            load_fire;
  logic            cnt_clear;
  logic            cnt_inc;

  serializer_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .count   (count),
    .is_last (is_last)
  );

  // Output decode from held state; serial_out only ever sees the shift register.
  always_comb begin
    busy         = (state_q == ST_SHIFT);
    serial_valid = busy;
    serial_out   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    frame_start  = busy && (count == '0);
    frame_end    = busy && is_last;
    load_ready   = !busy || (is_last && serial_ready);
    beat         = busy && serial_ready;
    load_fire    = load_valid && load_ready;
  end

  // Next state: a load (possibly overlapping the last beat) restarts the word,
  // otherwise a beat shifts one bit out and the last beat drops back to idle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (load_fire) begin
      state_d   = ST_SHIFT;
      shreg_d   = d;
      cnt_clear = 1'b1;
    end else if (beat) begin
      shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                          : {shreg_q[WIDTH-2:0], 1'b0};
      cnt_inc = 1'b1;
      if (is_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM and shift register state; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule
